// File: rtl/pckg_pkg.sv
// Shared types and helpers for the packet framer.
// PCKG_CRC8_EN selects the CRC-8 payload checksum instead of XOR.
package pckg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LEN,
        PAYLOAD,
        CSUM,
        NEXT
    } state_e;

    localparam logic [3:0] HDR_MARK = 4'hF;

    // CRC-8, poly 0x07, MSB-first, one byte per call
    function automatic logic [7:0] crc8_upd(
        input logic [7:0] crc,
        input logic [7:0] data
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/pckg_if.sv
// Framer bus: FIFO read side, channel select, TX word handshake.
// slave = framer, master = control block / FIFOs / transmitter.
interface pckg_if #(
    parameter int NUM_CH     = 3,
    parameter int WORD_BYTES = 3
);
    import pckg_pkg::*;

    localparam int CHW = $clog2(NUM_CH + 1);

    logic                    start;
    logic [NUM_CH-1:0]       rd_en;
    logic [NUM_CH*8-1:0]     fifo_data;
    logic [CHW-1:0]          ch_sel;
    logic                    next;
    logic                    tx_busy;
    logic [WORD_BYTES*8-1:0] data_out;
    logic                    tx_ena;

    modport slave (
        input  start, fifo_data, ch_sel, tx_busy,
        output rd_en, next, data_out, tx_ena
    );

    modport master (
        output start, fifo_data, ch_sel, tx_busy,
        input  rd_en, next, data_out, tx_ena
    );

endinterface

// File: rtl/pckg_word_asm.sv
// Payload word assembler: read strobes, byte-lane capture, ready flag.
// word_o already contains the byte being captured this cycle.
module pckg_word_asm
    import pckg_pkg::*;
#(
    parameter int WORD_BYTES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    take_i,
    input  logic [7:0]              byte_i,
    output logic                    rd_o,
    output logic                    cap_o,
    output logic [WORD_BYTES*8-1:0] word_o,
    output logic                    word_rdy_o
);

    localparam int CW = $clog2(WORD_BYTES + 1);

    logic [CW-1:0]           rd_cnt_q;
    logic [CW-1:0]           cap_cnt_q;
    logic                    rd_d1_q;
    logic [WORD_BYTES*8-1:0] word_q;
    logic [WORD_BYTES*8-1:0] word_d;

    assign rd_o  = en_i && (rd_cnt_q != CW'(WORD_BYTES));
    assign cap_o = rd_d1_q;

    always_comb begin
        word_d = word_q;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (rd_d1_q && cap_cnt_q == CW'(i)) begin
                word_d[8*i +: 8] = byte_i;
            end
        end
    end

    assign word_o     = word_d;
    assign word_rdy_o = (cap_cnt_q == CW'(WORD_BYTES)) ||
                        (rd_d1_q && cap_cnt_q == CW'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q  <= '0;
            cap_cnt_q <= '0;
            rd_d1_q   <= 1'b0;
            word_q    <= '0;
        end else begin
            rd_d1_q <= rd_o;
            word_q  <= word_d;
            if (take_i) begin
                rd_cnt_q  <= '0;
                cap_cnt_q <= '0;
            end else begin
                if (rd_o)    rd_cnt_q  <= rd_cnt_q + 1'b1;
                if (rd_d1_q) cap_cnt_q <= cap_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pckg_framer.sv
// Packet framer: header, length, payload words, checksum per frame.
// PCKG_CRC8_EN defined: CRC-8 checksum; undefined: XOR checksum.
module pckg_framer
    import pckg_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int WORD_BYTES    = 3,
    parameter int PAYLOAD_WORDS = 10,
    parameter int NODE_ID       = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    pckg_if.slave   bus
);

    localparam int CHW = $clog2(NUM_CH + 1);
    localparam int DW  = WORD_BYTES * 8;

    state_e          state_q, state_d;
    logic [CHW-1:0]  cur_ch_q, cur_ch_d;
    logic [7:0]      wcnt_q, wcnt_d;
    logic [7:0]      csum_q, csum_d, csum_upd;
    logic [DW-1:0]   data_q, data_d;
    logic            tx_ena_q, tx_ena_d;
    logic [7:0]      sel_byte;
    logic [DW-1:0]   asm_word;
    logic            asm_rd, asm_cap, asm_rdy, take, ch_ok;

    assign ch_ok        = 32'(bus.ch_sel) <= NUM_CH;
    assign bus.data_out = data_q;
    assign bus.tx_ena   = tx_ena_q;
    assign bus.next     = (state_q == NEXT);

    always_comb begin
        sel_byte   = '0;
        bus.rd_en  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_ch_q == CHW'(k + 1)) begin
                sel_byte     = bus.fifo_data[8*k +: 8];
                bus.rd_en[k] = asm_rd;
            end
        end
    end

`ifdef PCKG_CRC8_EN
    assign csum_upd = crc8_upd(csum_q, sel_byte);
`else
    assign csum_upd = csum_q ^ sel_byte;
`endif

    pckg_word_asm #(
        .WORD_BYTES (WORD_BYTES)
    ) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (state_q == PAYLOAD),
        .take_i     (take),
        .byte_i     (sel_byte),
        .rd_o       (asm_rd),
        .cap_o      (asm_cap),
        .word_o     (asm_word),
        .word_rdy_o (asm_rdy)
    );

    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        wcnt_d   = wcnt_q;
        data_d   = data_q;
        tx_ena_d = 1'b0;
        take     = 1'b0;
        csum_d   = asm_cap ? csum_upd : csum_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = HDR;
            HDR: if (!bus.tx_busy) begin
                cur_ch_d    = ch_ok ? bus.ch_sel : '0;
                data_d      = '0;
                data_d[7:0] = {HDR_MARK, 4'(NODE_ID)};
                tx_ena_d    = 1'b1;
                state_d     = LEN;
            end
            LEN: if (!bus.tx_busy) begin
                data_d   = '0;
                tx_ena_d = 1'b1;
                if (cur_ch_q != '0) begin
                    data_d[7:0] = 8'(PAYLOAD_WORDS);
                    state_d     = PAYLOAD;
                end else begin
                    state_d     = CSUM;
                end
            end
            PAYLOAD: if (asm_rdy && !bus.tx_busy) begin
                data_d   = asm_word;
                tx_ena_d = 1'b1;
                take     = 1'b1;
                if (wcnt_q == 8'(PAYLOAD_WORDS - 1)) begin
                    wcnt_d  = '0;
                    state_d = CSUM;
                end else begin
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end
            CSUM: if (!bus.tx_busy) begin
                data_d      = '0;
                data_d[7:0] = csum_q;
                tx_ena_d    = 1'b1;
                state_d     = NEXT;
            end
            NEXT: begin
                csum_d  = '0;
                state_d = HDR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cur_ch_q <= '0;
            wcnt_q   <= '0;
            csum_q   <= '0;
            data_q   <= '0;
            tx_ena_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
            wcnt_q   <= wcnt_d;
            csum_q   <= csum_d;
            data_q   <= data_d;
            tx_ena_q <= tx_ena_d;
        end
    end

endmodule

// File: tb/tb_pckg_framer.sv
// Directed bench for pckg_framer: default framer plus a 4-channel,
// 1-byte, 1-word framer for channel decode and checksum corners.
module tb_pckg_framer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    pckg_if #(.NUM_CH(3), .WORD_BYTES(3)) b0 ();
    pckg_if #(.NUM_CH(4), .WORD_BYTES(1)) b1 ();

    pckg_framer #(
        .NUM_CH(3), .WORD_BYTES(3), .PAYLOAD_WORDS(10), .NODE_ID(2)
    ) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

    pckg_framer #(
        .NUM_CH(4), .WORD_BYTES(1), .PAYLOAD_WORDS(1), .NODE_ID(2)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    // FIFO models: every channel yields 1, 2, 3, ... one cycle after rd_en
    int         rc0 [3];
    int         rc1 [4];
    logic [7:0] fd0 [3];
    logic [7:0] fd1 [4];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++)
            if (b0.rd_en[k]) begin
                rc0[k] <= rc0[k] + 1;
                fd0[k] <= 8'(rc0[k] + 1);
            end
        for (int k = 0; k < 4; k++)
            if (b1.rd_en[k]) begin
                rc1[k] <= rc1[k] + 1;
                fd1[k] <= 8'(rc1[k] + 1);
            end
    end

    assign b0.fifo_data = {fd0[2], fd0[1], fd0[0]};
    assign b1.fifo_data = {fd1[3], fd1[2], fd1[1], fd1[0]};

    logic [23:0] w0 [$];
    logic [23:0] w1 [$];
    int          t0 [$];
    int          nx0 = 0;
    bit          oh_bad = 1'b0;

    always @(negedge clk) begin
        if (b0.tx_ena) begin
            w0.push_back(b0.data_out);
            t0.push_back(cyc);
        end
        if (b1.tx_ena) w1.push_back(24'(b1.data_out));
        if (b0.next) nx0 = nx0 + 1;
        if (!$onehot0(b0.rd_en) || !$onehot0(b1.rd_en)) oh_bad = 1'b1;
    end

    function automatic logic [7:0] cs_step(input logic [7:0] c, input logic [7:0] b);
`ifdef PCKG_CRC8_EN
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ b[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
`else
        return c ^ b;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_next0(input int lim, output int n);
        n = 0;
        do begin tick(); n++; end while (!b0.next && n < lim);
    endtask

    task automatic wait_next1(input int lim, output int n);
        n = 0;
        do begin tick(); n++; end while (!b1.next && n < lim);
    endtask

    task automatic wait_w0(input int target, input int lim, output int n);
        n = 0;
        while (w0.size() < target && n < lim) begin tick(); n++; end
    endtask

    task automatic test_reset();
        b0.start = 1'b0; b0.ch_sel = '0; b0.tx_busy = 1'b0;
        b1.start = 1'b0; b1.ch_sel = '0; b1.tx_busy = 1'b0;
        tick();
        total++;
        if ({b0.tx_ena, b0.next, b0.rd_en, b0.data_out} !== '0) begin
            bad++;
            $display("FAIL reset_dut0 got=%h exp=0",
                     {b0.tx_ena, b0.next, b0.rd_en, b0.data_out});
        end
        total++;
        if ({b1.tx_ena, b1.next, b1.rd_en, b1.data_out} !== '0) begin
            bad++;
            $display("FAIL reset_dut1 got=%h exp=0",
                     {b1.tx_ena, b1.next, b1.rd_en, b1.data_out});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_data_packet();
        int s, n;
        logic [23:0] e;
        logic [7:0]  cs;
        s = w0.size();
        b0.ch_sel = 2'd2;
        b0.start  = 1'b1;
        wait_next0(300, n);
        total++;
        if (!b0.next) begin bad++; $display("FAIL p1_next got=0 exp=1"); end
        b0.ch_sel = 2'd0;
        total++;
        if (w0.size() - s !== 13) begin
            bad++; $display("FAIL p1_count got=%0d exp=13", w0.size() - s);
        end
        total++;
        if (w0[s] !== 24'h0000F2) begin
            bad++; $display("FAIL p1_hdr got=%h exp=0000f2", w0[s]);
        end
        total++;
        if (w0[s+1] !== 24'h00000A) begin
            bad++; $display("FAIL p1_len got=%h exp=00000a", w0[s+1]);
        end
        for (int j = 0; j < 10; j++) begin
            e = {8'(3*j+3), 8'(3*j+2), 8'(3*j+1)};
            total++;
            if (w0[s+2+j] !== e) begin
                bad++; $display("FAIL p1_word%0d got=%h exp=%h", j, w0[s+2+j], e);
            end
        end
        cs = 8'h00;
        for (int v = 1; v <= 30; v++) cs = cs_step(cs, 8'(v));
        total++;
        if (w0[s+12] !== {16'h0, cs}) begin
            bad++; $display("FAIL p1_csum got=%h exp=%h", w0[s+12], cs);
        end
        total++;
        if (t0[s+1] - t0[s] !== 1) begin
            bad++; $display("FAIL p1_hdr_len_gap got=%0d exp=1", t0[s+1] - t0[s]);
        end
        total++;
        if (t0[s+3] - t0[s+2] !== 4) begin
            bad++; $display("FAIL p1_word_gap got=%0d exp=4", t0[s+3] - t0[s+2]);
        end
        total++;
        if (rc0[1] !== 30 || rc0[0] + rc0[2] !== 0) begin
            bad++; $display("FAIL p1_reads got=%0d/%0d/%0d exp=0/30/0",
                            rc0[0], rc0[1], rc0[2]);
        end
    endtask

    task automatic test_empty_packet();
        int s, n;
        s = w0.size();
        wait_next0(50, n);
        total++;
        if (!b0.next) begin bad++; $display("FAIL p2_next got=0 exp=1"); end
        b0.ch_sel = 2'd2;
        total++;
        if (n !== 4) begin bad++; $display("FAIL p2_spacing got=%0d exp=4", n); end
        total++;
        if (w0.size() - s !== 3) begin
            bad++; $display("FAIL p2_count got=%0d exp=3", w0.size() - s);
        end
        total++;
        if ({w0[s], w0[s+1], w0[s+2]} !== {24'h0000F2, 24'h0, 24'h0}) begin
            bad++; $display("FAIL p2_words got=%h %h %h exp=0000f2 000000 000000",
                            w0[s], w0[s+1], w0[s+2]);
        end
        total++;
        if (rc0[1] !== 30 || rc0[0] + rc0[2] !== 0) begin
            bad++; $display("FAIL p2_reads got=%0d/%0d/%0d exp=0/30/0",
                            rc0[0], rc0[1], rc0[2]);
        end
    endtask

    task automatic test_busy_stall();
        int s, n;
        logic [23:0] d;
        logic [7:0]  cs;
        s = w0.size();
        wait_w0(s + 4, 100, n);
        total++;
        if (w0.size() < s + 4) begin
            bad++; $display("FAIL p3_wait got=%0d exp=%0d", w0.size(), s + 4);
        end
        b0.tx_busy = 1'b1;
        d = b0.data_out;
        total++;
        if (d !== 24'h242322) begin
            bad++; $display("FAIL p3_prev_word got=%h exp=242322", d);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            total++;
            if (b0.tx_ena !== 1'b0) begin
                bad++; $display("FAIL p3_busy_ena%0d got=%b exp=0", i, b0.tx_ena);
            end
            total++;
            if (b0.data_out !== d) begin
                bad++; $display("FAIL p3_busy_hold%0d got=%h exp=%h", i, b0.data_out, d);
            end
            if (i >= 2) begin
                total++;
                if (b0.rd_en !== 3'b000) begin
                    bad++; $display("FAIL p3_busy_rd%0d got=%b exp=000", i, b0.rd_en);
                end
            end
        end
        total++;
        if (rc0[1] !== 39) begin
            bad++; $display("FAIL p3_stall_reads got=%0d exp=39", rc0[1]);
        end
        b0.tx_busy = 1'b0;
        tick();
        total++;
        if (b0.tx_ena !== 1'b1 || b0.data_out !== 24'h272625) begin
            bad++; $display("FAIL p3_release got=%b/%h exp=1/272625",
                            b0.tx_ena, b0.data_out);
        end
        wait_next0(200, n);
        total++;
        if (!b0.next) begin bad++; $display("FAIL p3_next got=0 exp=1"); end
        total++;
        if (w0.size() - s !== 13) begin
            bad++; $display("FAIL p3_count got=%0d exp=13", w0.size() - s);
        end
        cs = 8'h00;
        for (int v = 31; v <= 60; v++) cs = cs_step(cs, 8'(v));
        total++;
        if (w0[s+12] !== {16'h0, cs}) begin
            bad++; $display("FAIL p3_csum got=%h exp=%h", w0[s+12], cs);
        end
    endtask

    task automatic test_channel_select();
        int s, n;
        logic [7:0] cs;
        s = w1.size();
        b1.ch_sel = 3'd3;
        b1.start  = 1'b1;
        wait_next1(50, n);
        total++;
        if (!b1.next) begin bad++; $display("FAIL ch3_next got=0 exp=1"); end
        b1.ch_sel = 3'd5;
        cs = cs_step(8'h00, 8'h01);
        total++;
        if (w1.size() - s !== 4) begin
            bad++; $display("FAIL ch3_count got=%0d exp=4", w1.size() - s);
        end
        total++;
        if ({w1[s], w1[s+1], w1[s+2]} !== {24'hF2, 24'h01, 24'h01}) begin
            bad++; $display("FAIL ch3_words got=%h %h %h exp=0000f2 000001 000001",
                            w1[s], w1[s+1], w1[s+2]);
        end
        total++;
        if (w1[s+3] !== {16'h0, cs}) begin
            bad++; $display("FAIL ch3_csum got=%h exp=%h", w1[s+3], cs);
        end
        total++;
        if (rc1[2] !== 1 || rc1[0] + rc1[1] + rc1[3] !== 0) begin
            bad++; $display("FAIL ch3_reads got=%0d/%0d/%0d/%0d exp=0/0/1/0",
                            rc1[0], rc1[1], rc1[2], rc1[3]);
        end
        s = w1.size();
        wait_next1(50, n);
        total++;
        if (!b1.next) begin bad++; $display("FAIL ch5_next got=0 exp=1"); end
        total++;
        if (w1.size() - s !== 3) begin
            bad++; $display("FAIL ch5_count got=%0d exp=3", w1.size() - s);
        end
        total++;
        if ({w1[s], w1[s+1], w1[s+2]} !== {24'hF2, 24'h0, 24'h0}) begin
            bad++; $display("FAIL ch5_words got=%h %h %h exp=0000f2 000000 000000",
                            w1[s], w1[s+1], w1[s+2]);
        end
        total++;
        if (rc1[2] !== 1 || rc1[0] + rc1[1] + rc1[3] !== 0) begin
            bad++; $display("FAIL ch5_reads got=%0d/%0d/%0d/%0d exp=0/0/1/0",
                            rc1[0], rc1[1], rc1[2], rc1[3]);
        end
    endtask

    task automatic test_reset_abort();
        int s, n, nx;
        wait_next0(200, n);
        total++;
        if (!b0.next) begin bad++; $display("FAIL p4_sync got=0 exp=1"); end
        s = w0.size();
        wait_w0(s + 6, 100, n);
        total++;
        if (w0.size() < s + 6) begin
            bad++; $display("FAIL p4_wait got=%0d exp=%0d", w0.size(), s + 6);
        end
        nx = nx0;
        rst_n = 1'b0;
        b0.start = 1'b0;
        #1;
        total++;
        if ({b0.tx_ena, b0.next, b0.rd_en, b0.data_out} !== '0) begin
            bad++; $display("FAIL p4_abort got=%h exp=0",
                            {b0.tx_ena, b0.next, b0.rd_en, b0.data_out});
        end
        tick();
        tick();
        rst_n = 1'b1;
        s = w0.size();
        tick();
        tick();
        total++;
        if (w0.size() !== s || b0.rd_en !== 3'b000) begin
            bad++; $display("FAIL p4_idle got=%0d/%b exp=%0d/000",
                            w0.size(), b0.rd_en, s);
        end
        b0.start = 1'b1;
        wait_w0(s + 1, 20, n);
        total++;
        if (w0[s] !== 24'h0000F2) begin
            bad++; $display("FAIL p4_fresh_hdr got=%h exp=0000f2", w0[s]);
        end
        total++;
        if (nx0 !== nx) begin
            bad++; $display("FAIL p4_no_next got=%0d exp=%0d", nx0, nx);
        end
    endtask

    initial begin
        test_reset();
        test_data_packet();
        test_empty_packet();
        test_busy_stall();
        test_channel_select();
        test_reset_abort();
        total++;
        if (oh_bad !== 1'b0) begin
            bad++; $display("FAIL rd_en_onehot got=%b exp=0", oh_bad);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
